apple_placer: RTL

- Sequential controller that places the apple after the snake eats it.
- Synchronises and edge-detects `goodColl`, then draws candidate coordinates from the external random source.
- Checks each candidate against the active snake body with one body segment compared per clock, instead of a 50-way parallel comparator. Retries on a collision, then commits the new apple coordinate.
- Sits between the game-logic collision detector and the pixel/display path, and drives the per-pixel `apple` flag.

---
 rtl/snake_pkg.sv | 12 +
 rtl/sync_rise_detect.sv | 27 ++
 rtl/apple_placer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game apple placement path.
package snake_pkg;

  localparam int unsigned MAX_LEN = 50;

  typedef logic [7:0] coord_t;

  localparam coord_t RESET_CORD = 8'hC5;

  typedef enum logic [1:0] {IDLE, LOAD, SCAN, COMMIT} placer_state_t;

endpackage

// File: rtl/sync_rise_detect.sv
// Two-flop synchroniser followed by a one-cycle rising-edge pulse.
module sync_rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic s1;
  logic s2;
  logic prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign rise = s2 & ~prev;

endmodule

// File: rtl/apple_placer.sv
// Places a new apple after each eat event, scanning the snake body one segment per clock.
// Optional bounded retries with place_fail reporting: define APPLE_RETRY_LIMIT_EN.
module apple_placer #(
  parameter int unsigned   MAX_LEN    = snake_pkg::MAX_LEN,
  parameter int unsigned   COORD_W    = 8,
  parameter int unsigned   MAX_TRIES  = 16,
  parameter logic [7:0]    RESET_CORD = snake_pkg::RESET_CORD
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       goodColl,
  input  logic [3:0]                 randX,
  input  logic [3:0]                 randY,
  input  logic [MAX_LEN*COORD_W-1:0] body,
  input  logic [5:0]                 length,
  input  logic [3:0]                 x,
  input  logic [3:0]                 y,
  output logic                       apple,
  output logic [COORD_W-1:0]         apple_cord,
  output logic                       apple_valid,
  output logic                       busy,
  output logic                       place_done,
  output logic                       place_fail
);

  import snake_pkg::*;

  localparam int unsigned LEN_W = 6;
  localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
  localparam logic [TRY_W-1:0] TRY_MAX = TRY_W'(MAX_TRIES);

  placer_state_t state;
  placer_state_t state_n;

  logic               rise;
  logic               pending;
  logic [COORD_W-1:0] cand;
  logic [LEN_W-1:0]   idx;
  logic [LEN_W-1:0]   len_c;
  logic [TRY_W-1:0]   try_cnt;
  logic [COORD_W-1:0] seg [MAX_LEN];
  logic               hit;
  logic               try_limit;

  logic start;
  logic load;
  logic step;
  logic commit;
  logic fail;

  sync_rise_detect u_coll_sync (
    .clk   (clk),
    .reset (reset),
    .din   (goodColl),
    .rise  (rise)
  );

  always_comb begin
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      seg[i] = body[i*COORD_W +: COORD_W];
    end
  end

  assign len_c = (length > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : length;
  assign hit   = (seg[idx] == cand);
  assign busy  = (state != IDLE);

`ifdef APPLE_RETRY_LIMIT_EN
  assign try_limit = (try_cnt == TRY_MAX);
`else
  assign try_limit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    commit  = 1'b0;
    fail    = 1'b0;
    case (state)
      IDLE: begin
        if (rise || pending) begin
          start   = 1'b1;
          state_n = LOAD;
        end
      end
      LOAD: begin
        if (try_limit) begin
          fail    = 1'b1;
          state_n = IDLE;
        end else begin
          load    = 1'b1;
          state_n = (len_c == '0) ? COMMIT : SCAN;
        end
      end
      SCAN: begin
        // A shrinking length can leave idx past the end: the scan is then complete with no hit.
        if (idx >= len_c)                   state_n = COMMIT;
        else if (hit)                       state_n = LOAD;
        else if ((idx + 6'd1) == len_c)     state_n = COMMIT;
        else                                step    = 1'b1;
      end
      COMMIT: begin
        commit  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending     <= 1'b0;
      cand        <= '0;
      idx         <= '0;
      try_cnt     <= '0;
      apple_cord  <= RESET_CORD;
      apple_valid <= 1'b1;
      apple       <= 1'b0;
      place_done  <= 1'b0;
      place_fail  <= 1'b0;
    end else begin
      place_done <= commit;
      place_fail <= fail;
      apple      <= apple_valid && (apple_cord == {x, y});

      // Only one eat event is queued; extra rises while pending collapse into it.
      if (start)     pending <= 1'b0;
      else if (rise) pending <= 1'b1;

      if (start) begin
        apple_valid <= 1'b0;
        try_cnt     <= '0;
      end

      if (load) begin
        cand    <= {randX, randY};
        idx     <= '0;
        try_cnt <= (try_cnt == TRY_MAX) ? try_cnt : try_cnt + 1'b1;
      end

      if (step) idx <= idx + 1'b1;

      if (commit) begin
        apple_cord  <= cand;
        apple_valid <= 1'b1;
      end

      if (fail) apple_valid <= 1'b1;
    end
  end

endmodule
